pattern_sweep_ctrl: RTL and testbench
=====================================

PATTERN_SWEEP_CTRL -- requirements
Module: pattern_sweep_ctrl

Interface
REQ-001 SHALL have parameter N_IN, default 3: width of DUT stimulus vector; legal range 1..16.
REQ-002 SHALL have parameter N_OUT, default 1: width of DUT response.
REQ-003 SHALL have parameter SETTLE, default 1: cycles each vector is held before capture; legal range 1..255.
REQ-004 SHALL have port CK, input, 1: the block's single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request to begin an exhaustive sweep; sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1: synchronous sweep cancel.
REQ-008 SHALL have port dut_in, output, N_IN: stimulus driven to the DUT.
REQ-009 SHALL have port dut_out, input, N_OUT: DUT response.
REQ-010 SHALL have port rec_valid, output, 1: result record valid.
REQ-011 SHALL have port rec_ready, input, 1: consumer accepts the record.
REQ-012 SHALL have port rec_vec, output, N_IN: stimulus of the record.
REQ-013 SHALL have port rec_resp, output, N_OUT: captured response of the record.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at sweep completion.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, EMIT and DONE.
REQ-017 IDLE: start=1 -> SETTLE next cycle, with dut_in=0 and settle counter loaded with SETTLE-1.
REQ-018 SETTLE: counter decrements each cycle; at count 0, rec_vec<=dut_in, rec_resp<=dut_out, rec_valid<=1 and the FSM goes to EMIT.
REQ-019 EMIT: rec_vec, rec_resp and rec_valid SHALL hold stable until the cycle in which rec_valid&&rec_ready.
REQ-020 On an EMIT handshake with dut_in != all-ones: rec_valid<=0, dut_in<=dut_in+1, counter reloaded, next state SETTLE.
REQ-021 On an EMIT handshake with dut_in == all-ones (wrap boundary): rec_valid<=0 and next state DONE; dut_in SHALL NOT wrap to 0 during the sweep.
REQ-022 DONE: done=1 for exactly one cycle, dut_in<=0, next state IDLE.
REQ-023 With rec_ready tied high, each vector SHALL take SETTLE+1 cycles, and done SHALL assert 2^N_IN*(SETTLE+1)+1 cycles after the start-sampling edge.
REQ-024 Exactly 2^N_IN records SHALL be emitted per sweep, in ascending vector order, with no duplicates or gaps under any backpressure pattern.
REQ-025 start while busy SHALL be ignored, with no effect on the current sweep.
REQ-026 abort=1 in any non-IDLE state -> IDLE next cycle, with rec_valid=0, dut_in=0 and no done pulse; abort has priority over a simultaneous handshake.
REQ-027 abort in IDLE SHALL be ignored; start and abort asserted together in IDLE -> stay in IDLE.

Reset
REQ-028 Asynchronous reset assertion SHALL force IDLE, dut_in=0, rec_valid=0, rec_vec=0, rec_resp=0, busy=0, done=0 and counter=0, including mid-sweep.
REQ-029 After reset deassertion the block SHALL wait in IDLE for start.

Configuration
REQ-030 With macro SWEEP_SIG_EN defined, the block SHALL add output port sig, 16 bits: a MISR that is reset to 16'hFFFF on reset or on sweep start.
REQ-031 With SWEEP_SIG_EN defined, on each record handshake sig<={sig[14:0],1'b0}^(sig[15]?16'h1021:16'h0)^zero-extended rec_resp; sig SHALL hold after DONE until the next start.
REQ-032 Without SWEEP_SIG_EN, port sig and all MISR logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the MISR polynomial constant 16'h1021 and the seed constant 16'hFFFF.
REQ-034 The MISR SHALL be one sub-module, sweep_misr, instantiated only under SWEEP_SIG_EN.

Verification
REQ-035 Defaults, rec_ready=1, dut_out=^dut_in, start pulsed at edge 0 -> records (000,0),(001,1),(010,1),(011,0),(100,1),(101,0),(110,0),(111,1); done pulses at edge 17.
REQ-036 rec_ready held low for 5 cycles during vector 3 -> rec_valid, rec_vec=011 and rec_resp held stable; vector 4 driven only after the handshake; 8 records total.
REQ-037 abort asserted while rec_vec=101 -> IDLE next cycle, rec_valid=0, dut_in=0, no done pulse; a later start restarts the sweep from 000.
REQ-038 reset asserted mid-SETTLE at vector 2 -> all outputs 0 immediately, without waiting for a clock edge.
REQ-039 SETTLE=3 -> each vector held 3 cycles before capture; done pulses at edge 33; start pulses asserted while busy produce no effect.
REQ-040 SWEEP_SIG_EN defined, scenario REQ-035 -> sig matches the reference-model MISR value after 8 updates; sig resets to FFFF on the next start.

Source files
------------

// File: rtl/pattern_sweep_ctrl_pkg.sv
// Shared definitions for the exhaustive pattern sweep controller: FSM state
// encoding, signature-register polynomial and seed, and the MISR step function
// used by the optional signature block (enabled with macro SWEEP_SIG_EN).
package pattern_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // One MISR update: shift left, fold the polynomial back in when the MSB
  // falls out, then mix in the (already zero-extended) response word.
  function automatic logic [15:0] misr_step(input logic [15:0] s,
                                            input logic [15:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ d;
  endfunction

endpackage

// File: rtl/pattern_sweep_ctrl_misr.sv
// 16-bit multiple-input signature register that compresses every accepted
// response record of a sweep. Only instantiated when SWEEP_SIG_EN is defined.
module sweep_misr
  import pattern_sweep_ctrl_pkg::*;
#(
  parameter int N_OUT = 1
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             clear,
  input  logic             upd,
  input  logic [N_OUT-1:0] data,
  output logic [15:0]      sig
);

  logic [15:0] sig_q;

  // Seed on reset or sweep start, otherwise fold in each accepted response.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      sig_q <= MISR_SEED;
    end else if (clear) begin
      sig_q <= MISR_SEED;
    end else if (upd) begin
      sig_q <= misr_step(sig_q, 16'(data));
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/pattern_sweep_ctrl.sv
// Exhaustive stimulus sweep controller. Drives every N_IN-bit vector to a
// device under test in ascending order, waits SETTLE cycles per vector,
// captures the response and hands it out as a valid/ready record.
// Optional: define SWEEP_SIG_EN to add a 16-bit response signature port (sig).
module pattern_sweep_ctrl
  import pattern_sweep_ctrl_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [N_IN-1:0]  rec_vec,
  output logic [N_OUT-1:0] rec_resp,
`ifdef SWEEP_SIG_EN
  output logic [15:0]      sig,
`endif
  output logic             busy,
  output logic             done
);

  // Last vector of the sweep; reaching it ends the sweep instead of wrapping.
  localparam logic [N_IN-1:0] VEC_LAST = '1;
  // Counter reload so that a vector spends exactly SETTLE cycles in SETTLE.
  localparam logic [7:0]      CNT_LOAD = 8'(SETTLE - 1);

  sweep_state_e     state_q;
  logic [7:0]       cnt_q;
  logic [N_IN-1:0]  dut_in_q;
  logic             rec_valid_q;
  logic [N_IN-1:0]  rec_vec_q;
  logic [N_OUT-1:0] rec_resp_q;
  logic             done_q;

  // Sweep FSM with all outputs registered; abort overrides any other activity.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dut_in_q    <= '0;
      rec_valid_q <= 1'b0;
      rec_vec_q   <= '0;
      rec_resp_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
        state_q     <= ST_IDLE;
        cnt_q       <= '0;
        dut_in_q    <= '0;
        rec_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // abort in IDLE is ignored, but start+abort together must not launch.
            if (start && !abort) begin
              state_q  <= ST_SETTLE;
              dut_in_q <= '0;
              cnt_q    <= CNT_LOAD;
            end
          end
          ST_SETTLE: begin
            if (cnt_q == 8'd0) begin
              rec_vec_q   <= dut_in_q;
              rec_resp_q  <= dut_out;
              rec_valid_q <= 1'b1;
              state_q     <= ST_EMIT;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          ST_EMIT: begin
            // rec_valid is always high here, so rec_ready alone completes the handshake.
            if (rec_ready) begin
              rec_valid_q <= 1'b0;
              if (dut_in_q == VEC_LAST) begin
                state_q <= ST_DONE;
              end else begin
                dut_in_q <= dut_in_q + 1'b1;
                cnt_q    <= CNT_LOAD;
                state_q  <= ST_SETTLE;
              end
            end
          end
          ST_DONE: begin
            done_q   <= 1'b1;
            dut_in_q <= '0;
            state_q  <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign dut_in    = dut_in_q;
  assign rec_valid = rec_valid_q;
  assign rec_vec   = rec_vec_q;
  assign rec_resp  = rec_resp_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef SWEEP_SIG_EN
  logic sweep_start;
  logic rec_hs;

  // Signature is seeded when a sweep launches and updated on every accepted
  // record; an aborted handshake does not count as accepted.
  assign sweep_start = (state_q == ST_IDLE) && start && !abort;
  assign rec_hs      = (state_q == ST_EMIT) && rec_valid_q && rec_ready && !abort;

  sweep_misr #(
    .N_OUT(N_OUT)
  ) u_misr (
    .CK   (CK),
    .reset(reset),
    .clear(sweep_start),
    .upd  (rec_hs),
    .data (rec_resp_q),
    .sig  (sig)
  );
`endif

endmodule

// File: tb/tb_pattern_sweep_ctrl.sv
// Directed bench for pattern_sweep_ctrl. Instance A uses defaults (N_IN=3,
// SETTLE=1); instance B uses SETTLE=3. Both DUT models respond with ^dut_in.
module tb_pattern_sweep_ctrl;

  logic       CK = 1'b0;
  logic       reset = 1'b0;
  logic       start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1;
  logic       start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1;
  logic [2:0] dut_in_a, rvec_a, dut_in_b, rvec_b;
  logic [0:0] dut_out_a, rresp_a, dut_out_b, rresp_b;
  logic       rv_a, busy_a, done_a, rv_b, busy_b, done_b;
`ifdef SWEEP_SIG_EN
  logic [15:0] sig_a, sig_b;
`endif

  int checks = 0;
  int errors = 0;

  // Hand-computed parity of vectors 0..7.
  int EXP_RESP [8] = '{0, 1, 1, 0, 1, 0, 0, 1};

  assign dut_out_a = ^dut_in_a;
  assign dut_out_b = ^dut_in_b;

  pattern_sweep_ctrl #(.N_IN(3), .N_OUT(1), .SETTLE(1)) u_a (
    .CK(CK), .reset(reset), .start(start_a), .abort(abort_a),
    .dut_in(dut_in_a), .dut_out(dut_out_a),
    .rec_valid(rv_a), .rec_ready(ready_a), .rec_vec(rvec_a), .rec_resp(rresp_a),
`ifdef SWEEP_SIG_EN
    .sig(sig_a),
`endif
    .busy(busy_a), .done(done_a)
  );

  pattern_sweep_ctrl #(.N_IN(3), .N_OUT(1), .SETTLE(3)) u_b (
    .CK(CK), .reset(reset), .start(start_b), .abort(abort_b),
    .dut_in(dut_in_b), .dut_out(dut_out_b),
    .rec_valid(rv_b), .rec_ready(ready_b), .rec_vec(rvec_b), .rec_resp(rresp_b),
`ifdef SWEEP_SIG_EN
    .sig(sig_b),
`endif
    .busy(busy_b), .done(done_b)
  );

  always #5 CK = ~CK;

  task automatic test_reset();
    #1 reset = 1'b1;
    @(negedge CK);
    @(negedge CK);
    checks++; if (dut_in_a !== 3'd0) begin errors++; $display("FAIL reset_dut_in got %0d want 0", dut_in_a); end
    checks++; if (rv_a !== 1'b0) begin errors++; $display("FAIL reset_rec_valid got %0b want 0", rv_a); end
    checks++; if (rvec_a !== 3'd0) begin errors++; $display("FAIL reset_rec_vec got %0d want 0", rvec_a); end
    checks++; if (rresp_a !== 1'b0) begin errors++; $display("FAIL reset_rec_resp got %0b want 0", rresp_a); end
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b/%0b want 0/0", busy_a, busy_b); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done_a); end
    reset = 1'b0;
    // abort alone in IDLE is ignored
    abort_a = 1'b1;
    @(negedge CK);
    abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_abort_busy got %0b want 0", busy_a); end
    // start together with abort in IDLE stays in IDLE
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge CK);
    start_a = 1'b0; abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL start_abort_busy got %0b want 0", busy_a); end
    repeat (3) @(negedge CK);
    checks++; if (busy_a !== 1'b0 || rv_a !== 1'b0) begin errors++; $display("FAIL idle_wait got busy %0b valid %0b want 0 0", busy_a, rv_a); end
  endtask

  task automatic test_sweep();
    int n = 0;
    int vec [8];
    int resp [8];
    int cyc_of [8];
    int done_cyc = -1;
    int done_n = 0;
    for (int i = 0; i < 8; i++) begin vec[i] = -1; resp[i] = -1; cyc_of[i] = -1; end
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge CK);
    start_a = 1'b0;
    for (int cyc = 0; cyc < 22; cyc++) begin
      if (cyc > 0) @(negedge CK);
      if (cyc == 0) begin
        checks++; if (busy_a !== 1'b1 || dut_in_a !== 3'd0) begin errors++; $display("FAIL sweep_launch got busy %0b dut_in %0d want 1 0", busy_a, dut_in_a); end
      end
      if (done_a === 1'b1) begin done_n++; if (done_cyc < 0) done_cyc = cyc; end
      if (rv_a === 1'b1 && ready_a) begin
        if (n < 8) begin vec[n] = rvec_a; resp[n] = rresp_a; cyc_of[n] = cyc; end
        n++;
      end
    end
    checks++; if (n != 8) begin errors++; $display("FAIL sweep_count got %0d want 8", n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (vec[i] != i || resp[i] != EXP_RESP[i] || cyc_of[i] != 2 * i + 1) begin
        errors++;
        $display("FAIL sweep_rec%0d got vec %0d resp %0d cyc %0d want %0d %0d %0d", i, vec[i], resp[i], cyc_of[i], i, EXP_RESP[i], 2 * i + 1);
      end
    end
    checks++; if (done_cyc != 17 || done_n != 1) begin errors++; $display("FAIL sweep_done got edge %0d pulses %0d want 17 1", done_cyc, done_n); end
    checks++; if (dut_in_a !== 3'd0 || busy_a !== 1'b0) begin errors++; $display("FAIL sweep_end got dut_in %0d busy %0b want 0 0", dut_in_a, busy_a); end
  endtask

  task automatic test_sig();
`ifdef SWEEP_SIG_EN
    logic [15:0] s = 16'hFFFF;
    for (int i = 0; i < 8; i++)
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ 16'(EXP_RESP[i]);
    checks++; if (sig_a !== s) begin errors++; $display("FAIL sig_value got %h want %h", sig_a, s); end
    start_a = 1'b1;
    @(negedge CK);
    start_a = 1'b0;
    checks++; if (sig_a !== 16'hFFFF) begin errors++; $display("FAIL sig_seed got %h want ffff", sig_a); end
    abort_a = 1'b1;
    @(negedge CK);
    abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL sig_abort_busy got %0b want 0", busy_a); end
`endif
  endtask

  task automatic test_backpressure();
    int n = 0;
    int hold = 0;
    int done_cyc = -1;
    int vec [8];
    int resp [8];
    for (int i = 0; i < 8; i++) begin vec[i] = -1; resp[i] = -1; end
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge CK);
    start_a = 1'b0;
    for (int cyc = 0; cyc < 60 && done_cyc < 0; cyc++) begin
      if (cyc > 0) @(negedge CK);
      if (done_a === 1'b1) done_cyc = cyc;
      if (rv_a === 1'b1 && rvec_a === 3'd3 && hold < 5) begin
        ready_a = 1'b0;
        hold++;
        checks++;
        if (rresp_a !== 1'b0 || dut_in_a !== 3'd3) begin
          errors++;
          $display("FAIL bp_hold%0d got resp %0b dut_in %0d want 0 3", hold, rresp_a, dut_in_a);
        end
      end else begin
        ready_a = 1'b1;
        if (rv_a === 1'b1) begin
          if (n < 8) begin vec[n] = rvec_a; resp[n] = rresp_a; end
          n++;
        end
      end
    end
    ready_a = 1'b1;
    checks++; if (hold != 5) begin errors++; $display("FAIL bp_hold_cycles got %0d want 5", hold); end
    checks++; if (n != 8) begin errors++; $display("FAIL bp_count got %0d want 8", n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (vec[i] != i || resp[i] != EXP_RESP[i]) begin
        errors++;
        $display("FAIL bp_rec%0d got vec %0d resp %0d want %0d %0d", i, vec[i], resp[i], i, EXP_RESP[i]);
      end
    end
    checks++; if (done_cyc != 22) begin errors++; $display("FAIL bp_done got edge %0d want 22", done_cyc); end
  endtask

  task automatic test_abort();
    bit aborted = 0;
    bit done_seen = 0;
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge CK);
    start_a = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge CK);
      if (rv_a === 1'b1 && rvec_a === 3'd5) begin
        // handshake and abort in the same cycle: abort wins
        abort_a = 1'b1;
        @(negedge CK);
        abort_a = 1'b0;
        aborted = 1;
        break;
      end
    end
    checks++; if (!aborted) begin errors++; $display("FAIL abort_reach got no record 5 want record 5"); end
    checks++;
    if (busy_a !== 1'b0 || rv_a !== 1'b0 || dut_in_a !== 3'd0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got busy %0b valid %0b dut_in %0d done %0b want 0 0 0 0", busy_a, rv_a, dut_in_a, done_a);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CK);
      if (done_a === 1'b1 || busy_a === 1'b1) done_seen = 1;
    end
    checks++; if (done_seen) begin errors++; $display("FAIL abort_quiet got done/busy activity want none"); end
    start_a = 1'b1;
    @(negedge CK);
    start_a = 1'b0;
    checks++; if (busy_a !== 1'b1 || dut_in_a !== 3'd0) begin errors++; $display("FAIL restart_launch got busy %0b dut_in %0d want 1 0", busy_a, dut_in_a); end
    @(negedge CK);
    checks++; if (rv_a !== 1'b1 || rvec_a !== 3'd0) begin errors++; $display("FAIL restart_first got valid %0b vec %0d want 1 0", rv_a, rvec_a); end
    done_seen = 0;
    for (int cyc = 0; cyc < 30 && !done_seen; cyc++) begin
      @(negedge CK);
      if (done_a === 1'b1) done_seen = 1;
    end
    checks++; if (!done_seen) begin errors++; $display("FAIL restart_done got no done want done within 30 cycles"); end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge CK);
    start_a = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) @(negedge CK);
      if (dut_in_a === 3'd2 && rv_a === 1'b0 && busy_a === 1'b1) begin found = 1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach got no settle at vector 2 want settle at vector 2"); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dut_in_a !== 3'd0 || rv_a !== 1'b0 || rvec_a !== 3'd0 || rresp_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got dut_in %0d valid %0b vec %0d resp %0b busy %0b done %0b want all 0",
               dut_in_a, rv_a, rvec_a, rresp_a, busy_a, done_a);
    end
    @(negedge CK);
    reset = 1'b0;
    @(negedge CK);
    checks++; if (busy_a !== 1'b0 || dut_in_a !== 3'd0) begin errors++; $display("FAIL rstmid_idle got busy %0b dut_in %0d want 0 0", busy_a, dut_in_a); end
  endtask

  task automatic test_settle3();
    int n = 0;
    int vec [8];
    int resp [8];
    int cyc_of [8];
    int done_cyc = -1;
    int done_n = 0;
    for (int i = 0; i < 8; i++) begin vec[i] = -1; resp[i] = -1; cyc_of[i] = -1; end
    ready_b = 1'b1;
    start_b = 1'b1;
    @(negedge CK);
    start_b = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge CK);
      if (done_b === 1'b1) begin done_n++; if (done_cyc < 0) done_cyc = cyc; end
      if (rv_b === 1'b1) begin
        if (n < 8) begin vec[n] = rvec_b; resp[n] = rresp_b; cyc_of[n] = cyc; end
        n++;
      end
      // start while busy must be ignored
      start_b = (cyc == 5 || cyc == 20);
    end
    start_b = 1'b0;
    checks++; if (n != 8) begin errors++; $display("FAIL s3_count got %0d want 8", n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (vec[i] != i || resp[i] != EXP_RESP[i] || cyc_of[i] != 4 * i + 3) begin
        errors++;
        $display("FAIL s3_rec%0d got vec %0d resp %0d cyc %0d want %0d %0d %0d", i, vec[i], resp[i], cyc_of[i], i, EXP_RESP[i], 4 * i + 3);
      end
    end
    checks++; if (done_cyc != 33 || done_n != 1) begin errors++; $display("FAIL s3_done got edge %0d pulses %0d want 33 1", done_cyc, done_n); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_sig();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_settle3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
